// File: rtl/mem_port_arbiter.sv
// Two-port arbiter in front of the shared instruction/data memory: port 0 is the core, port 1
// the boot loader/DMA. Define ARB_ROUND_ROBIN_EN for alternating priority; default is fixed.
module mem_port_arbiter #(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned RD_LAT = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                p0_req,
    input  logic                p0_we,
    input  logic [ADDR_W-1:0]   p0_addr,
    input  logic [DATA_W-1:0]   p0_wdata,
    input  logic [DATA_W/8-1:0] p0_wmask,
    output logic                p0_done,
    output logic [DATA_W-1:0]   p0_rdata,
    input  logic                p1_req,
    input  logic                p1_we,
    input  logic [ADDR_W-1:0]   p1_addr,
    input  logic [DATA_W-1:0]   p1_wdata,
    input  logic [DATA_W/8-1:0] p1_wmask,
    output logic                p1_done,
    output logic [DATA_W-1:0]   p1_rdata,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_we,
    output logic [DATA_W-1:0]   mem_wdata,
    output logic [DATA_W/8-1:0] mem_wmask,
    input  logic [DATA_W-1:0]   mem_rdata,
    output logic                busy
);

    localparam int unsigned MASK_W = DATA_W / 8;
    localparam int unsigned CNT_W  = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(RD_LAT - 1);

    typedef enum logic [1:0] {StIdle, StAccess, StWait, StDone} state_e;

    state_e              state_q, state_d;
    logic                sel_q, sel_d;
    logic                we_q, we_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
    logic [MASK_W-1:0]   mem_wmask_q, mem_wmask_d;
    logic                mem_we_q, mem_we_d;
    logic                p0_done_q, p0_done_d;
    logic                p1_done_q, p1_done_d;
    logic [DATA_W-1:0]   p0_rdata_q, p0_rdata_d;
    logic [DATA_W-1:0]   p1_rdata_q, p1_rdata_d;
    logic                busy_q, busy_d;

    logic                any_req;
    logic                win;
    logic                win_we;
    logic [ADDR_W-1:0]   win_addr;
    logic [DATA_W-1:0]   win_wdata;
    logic [MASK_W-1:0]   win_wmask;

    assign any_req = p0_req | p1_req;

`ifdef ARB_ROUND_ROBIN_EN
    // prio_q names the port that wins a tie; it flips away from every granted port.
    logic prio_q, prio_d;

    assign win = (p0_req && p1_req) ? prio_q : ~p0_req;

    always_comb begin
        prio_d = prio_q;
        if (state_q == StIdle && any_req) begin
            prio_d = ~win;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prio_q <= 1'b0;
        end else begin
            prio_q <= prio_d;
        end
    end
`else
    assign win = ~p0_req;
`endif

    assign win_we    = win ? p1_we    : p0_we;
    assign win_addr  = win ? p1_addr  : p0_addr;
    assign win_wdata = win ? p1_wdata : p0_wdata;
    assign win_wmask = win ? p1_wmask : p0_wmask;

    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        we_d        = we_q;
        cnt_d       = cnt_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_wmask_d = mem_wmask_q;
        mem_we_d    = 1'b0;
        p0_done_d   = 1'b0;
        p1_done_d   = 1'b0;
        p0_rdata_d  = p0_rdata_q;
        p1_rdata_d  = p1_rdata_q;

        unique case (state_q)
            StIdle: begin
                if (any_req) begin
                    sel_d       = win;
                    we_d        = win_we;
                    mem_addr_d  = win_addr;
                    mem_wdata_d = win_wdata;
                    mem_wmask_d = win_wmask;
                    mem_we_d    = win_we;
                    state_d     = StAccess;
                end
            end
            StAccess: begin
                if (we_q) begin
                    p0_done_d = ~sel_q;
                    p1_done_d = sel_q;
                    state_d   = StDone;
                end else begin
                    cnt_d   = CNT_LOAD;
                    state_d = StWait;
                end
            end
            StWait: begin
                // Memory data is valid only in the last wait cycle.
                if (cnt_q == '0) begin
                    if (sel_q) begin
                        p1_rdata_d = mem_rdata;
                    end else begin
                        p0_rdata_d = mem_rdata;
                    end
                    p0_done_d = ~sel_q;
                    p1_done_d = sel_q;
                    state_d   = StDone;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        busy_d = (state_d != StIdle);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= StIdle;
            sel_q       <= 1'b0;
            we_q        <= 1'b0;
            cnt_q       <= '0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_wmask_q <= '0;
            mem_we_q    <= 1'b0;
            p0_done_q   <= 1'b0;
            p1_done_q   <= 1'b0;
            p0_rdata_q  <= '0;
            p1_rdata_q  <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            we_q        <= we_d;
            cnt_q       <= cnt_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_wmask_q <= mem_wmask_d;
            mem_we_q    <= mem_we_d;
            p0_done_q   <= p0_done_d;
            p1_done_q   <= p1_done_d;
            p0_rdata_q  <= p0_rdata_d;
            p1_rdata_q  <= p1_rdata_d;
            busy_q      <= busy_d;
        end
    end

    assign mem_addr  = mem_addr_q;
    assign mem_we    = mem_we_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_wmask = mem_wmask_q;
    assign p0_done   = p0_done_q;
    assign p1_done   = p1_done_q;
    assign p0_rdata  = p0_rdata_q;
    assign p1_rdata  = p1_rdata_q;
    assign busy      = busy_q;

endmodule
